cram_arbiter: RTL
=================

# cram_arbiter

Shares the single-port, byte-wide cartridge RAM between three requesters:
- the CPU path, using the mapper-translated cart RAM address;
- mapper-internal writes, i.e. the MBC7 EEPROM and TAMA write-back;
- the 16-bit backup-RAM save/load channel.

It sits between the mapper block and the cart RAM. It never stalls CPU accesses, buffers mapper writes one deep, and sequences backup words as two byte accesses.

## Interface
Parameters:
- ADDR_W, 17, cart RAM byte address width
- BK_AW, 16, backup word address width (ADDR_W-1)

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_cpu  in  1  CPU access slot strobe; never high two consecutive cycles
- cpu_rd  in  1  CPU read request, qualified by ce_cpu
- cpu_wr  in  1  CPU write request, qualified by ce_cpu
- cpu_addr  in  ADDR_W  mapper-translated byte address
- cpu_di  in  8  CPU write data
- cpu_do  out  8  registered CPU read data
- mw_req  in  1  mapper write pulse
- mw_addr  in  ADDR_W  mapper write address
- mw_data  in  8  mapper write data
- mw_busy  out  1  mapper write buffer full
- bk_req  in  1  backup access request, level, held until bk_ack
- bk_we  in  1  1 = write word, 0 = read word
- bk_addr  in  BK_AW  backup word address
- bk_din  in  16  backup write word
- bk_dout  out  16  backup read word, little-endian
- bk_ack  out  1  one-cycle completion pulse
- ram_addr  out  ADDR_W  cart RAM address
- ram_we  out  1  cart RAM write enable
- ram_d  out  8  cart RAM write data
- ram_q  in  8  cart RAM read data, valid 1 cycle after address

## Operation
- Per-cycle grant, fixed priority:
  1. CPU, when ce_cpu & (cpu_rd | cpu_wr);
  2. mapper write buffer, when full;
  3. backup sequencer, when it has a pending byte access;
  4. idle: ram_we=0, ram_addr holds its last value.
- cpu_rd and cpu_wr both high: the write wins.
- CPU grant:
  - write: ram_we=1 with cpu_addr and cpu_di;
  - read: cpu_do loads ram_q on the next cycle and holds until the next CPU read.
- Mapper write buffer, one entry:
  - mw_req loads addr/data and sets mw_busy;
  - mw_busy clears on the cycle the entry is granted;
  - mw_req in that same drain cycle reloads the buffer and mw_busy stays high;
  - mw_req while mw_busy and not draining is dropped.
- Backup FSM, states B_IDLE, B_LO, B_HI, B_FIN:
  - B_IDLE -> B_LO when bk_req.
  - B_LO issues byte address {bk_addr,0} (write data bk_din[7:0]). It advances only when granted, otherwise it holds.
  - B_HI issues {bk_addr,1} (write data bk_din[15:8]) and captures bk_dout[7:0] from ram_q on a read. It advances when granted.
  - B_FIN captures bk_dout[15:8] on a read, pulses bk_ack, then returns to B_IDLE.
- Read capture uses a registered "issued last cycle" flag per source, so a preempting CPU grant never corrupts backup data.
- bk_addr, bk_we and bk_din are sampled at B_IDLE -> B_LO. Later changes are ignored until bk_ack.

## Timing
- Reset values: cpu_do=8'hFF, bk_dout=0, bk_ack=0, mw_busy=0, ram_we=0, ram_addr=0, ram_d=0, FSM=B_IDLE, buffer empty.
- ram_addr, ram_we and ram_d are combinational from the grant, so a CPU access adds zero cycles.
- cpu_do is valid 1 cycle after the CPU slot.
- Mapper write latency: 1 cycle when idle; worst case 2 cycles, because the CPU slot is never consecutive.
- Backup word with no contention: bk_req rises at T, bk_ack pulses at T+3.
  - Each CPU grant during B_LO/B_HI adds 1 cycle.
  - A pending mapper write adds 1 cycle.
- Next backup access: bk_req may remain high after bk_ack; the next word starts at the cycle after the ack.
- Reset mid-operation: the FSM aborts to B_IDLE, no bk_ack, the buffer is cleared, and a partial backup write may leave the low byte written.
- Address arithmetic is unsigned concatenation only, with no wrap logic.

## Structure
- Package cram_arb_pkg holds:
  - bk_state_t enum (B_IDLE, B_LO, B_HI, B_FIN);
  - grant_t enum (G_NONE, G_CPU, G_MW, G_BK);
  - ADDR_W and BK_AW defaults.
- One sub-module, cram_bk_seq: the backup FSM plus word assembly. It exposes a byte request/grant pair to the arbiter top.
- The grant mux and mapper buffer live in the top.

## Test plan
- CPU write 8'h5A @17'h00123 on a ce_cpu slot, then a CPU read of the same address: ram_we=1 in the same cycle, and cpu_do=8'h5A one cycle after the read slot.
- mw_req (17'h00010, 8'hC3) coinciding with a CPU write:
  - CPU granted first, mw_busy=1;
  - mapper write issued the next cycle, mw_busy=0 after it.
- Backup write bk_addr=16'h0008, bk_din=16'hBEEF, no contention: bytes EF @17'h00010 then BE @17'h00011; bk_ack at T+3.
- Backup read of that word with ce_cpu CPU reads interleaved every other cycle: bk_dout=16'hBEEF, bk_ack delayed by the number of CPU grants, and cpu_do unaffected.
- Second mw_req while mw_busy and not draining: dropped, and only the first write reaches RAM.
- reset asserted during B_HI: outputs return to reset values the next cycle and no bk_ack occurs. A new bk_req then completes normally.

Source files
------------

// File: rtl/cram_arb_pkg.sv
// Shared types and default widths for the cart RAM arbiter and its backup sequencer.
package cram_arb_pkg;

    localparam int ADDR_W_DEF = 17;
    localparam int BK_AW_DEF  = 16;

    typedef enum logic [1:0] {
        B_IDLE,
        B_LO,
        B_HI,
        B_FIN
    } bk_state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_CPU,
        G_MW,
        G_BK
    } grant_t;

endpackage

// File: rtl/cram_bk_seq.sv
// Backup-RAM word sequencer: splits a 16-bit save/load into two byte accesses
// and reassembles the little-endian read word.
//
// state  | meaning
// B_IDLE | waiting for bk_req, request latched on exit
// B_LO   | low byte access pending, holds until granted
// B_HI   | high byte access pending, low read byte captured here
// B_FIN  | high read byte arrives, bk_ack high for this one cycle
module cram_bk_seq
    import cram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BK_AW  = BK_AW_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              bk_req,
    input  logic              bk_we,
    input  logic [BK_AW-1:0]  bk_addr,
    input  logic [15:0]       bk_din,
    output logic [15:0]       bk_dout,
    output logic              bk_ack,
    output logic              byte_req,
    output logic [ADDR_W-1:0] byte_addr,
    output logic              byte_we,
    output logic [7:0]        byte_d,
    input  logic              byte_gnt,
    input  logic [7:0]        ram_q
);

    bk_state_t        state_q;
    logic [BK_AW-1:0] addr_q;
    logic             we_q;
    logic [15:0]      din_q;
    logic [15:0]      dout_q;
    logic             ack_q;
    logic             rd_iss_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= B_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            din_q    <= '0;
            dout_q   <= '0;
            ack_q    <= 1'b0;
            rd_iss_q <= 1'b0;
        end else begin
            ack_q    <= 1'b0;
            rd_iss_q <= byte_gnt & ~we_q;
            // The flag only marks cycles where our own read was on the bus,
            // so a CPU preemption in between never lands in the word.
            if (rd_iss_q && state_q == B_HI)  dout_q[7:0]  <= ram_q;
            if (rd_iss_q && state_q == B_FIN) dout_q[15:8] <= ram_q;
            case (state_q)
                B_IDLE: begin
                    if (bk_req) begin
                        state_q <= B_LO;
                        addr_q  <= bk_addr;
                        we_q    <= bk_we;
                        din_q   <= bk_din;
                    end
                end
                B_LO:    if (byte_gnt) state_q <= B_HI;
                B_HI: begin
                    if (byte_gnt) begin
                        state_q <= B_FIN;
                        ack_q   <= 1'b1;
                    end
                end
                B_FIN:   state_q <= B_IDLE;
                default: state_q <= B_IDLE;
            endcase
        end
    end

    assign byte_req  = (state_q == B_LO) || (state_q == B_HI);
    assign byte_addr = {addr_q, state_q == B_HI};
    assign byte_we   = we_q;
    assign byte_d    = (state_q == B_HI) ? din_q[15:8] : din_q[7:0];
    assign bk_ack    = ack_q;
    // High byte is forwarded straight from the RAM so the word is complete during the ack.
    assign bk_dout   = (rd_iss_q && state_q == B_FIN) ? {ram_q, dout_q[7:0]} : dout_q;

endmodule

// File: rtl/cram_arbiter.sv
// Cart RAM arbiter: fixed-priority grant between CPU, a one-deep mapper write
// buffer and the backup word sequencer; RAM controls are combinational from the grant.
module cram_arbiter
    import cram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BK_AW  = BK_AW_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_cpu,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_di,
    output logic [7:0]        cpu_do,
    input  logic              mw_req,
    input  logic [ADDR_W-1:0] mw_addr,
    input  logic [7:0]        mw_data,
    output logic              mw_busy,
    input  logic              bk_req,
    input  logic              bk_we,
    input  logic [BK_AW-1:0]  bk_addr,
    input  logic [15:0]       bk_din,
    output logic [15:0]       bk_dout,
    output logic              bk_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_d,
    input  logic [7:0]        ram_q
);

    grant_t            grant;
    logic              cpu_act;
    logic              mw_full_q, mw_full_d;
    logic [ADDR_W-1:0] mw_addr_q, mw_addr_d;
    logic [7:0]        mw_data_q, mw_data_d;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_d_q;
    logic [7:0]        cpu_do_q;
    logic              cpu_rd_iss_q;

    logic              bk_byte_req;
    logic [ADDR_W-1:0] bk_byte_addr;
    logic              bk_byte_we;
    logic [7:0]        bk_byte_d;

    cram_bk_seq #(.ADDR_W(ADDR_W), .BK_AW(BK_AW)) u_bk_seq (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .bk_req    (bk_req),
        .bk_we     (bk_we),
        .bk_addr   (bk_addr),
        .bk_din    (bk_din),
        .bk_dout   (bk_dout),
        .bk_ack    (bk_ack),
        .byte_req  (bk_byte_req),
        .byte_addr (bk_byte_addr),
        .byte_we   (bk_byte_we),
        .byte_d    (bk_byte_d),
        .byte_gnt  (grant == G_BK),
        .ram_q     (ram_q)
    );

    always_comb begin
        cpu_act   = ce_cpu & (cpu_rd | cpu_wr);
        grant     = G_NONE;
        ram_addr  = ram_addr_q;
        ram_d     = ram_d_q;
        ram_we    = 1'b0;
        mw_full_d = mw_full_q;
        mw_addr_d = mw_addr_q;
        mw_data_d = mw_data_q;

        // Nothing reaches the RAM while reset is held.
        if (!reset) begin
            if (cpu_act)          grant = G_CPU;
            else if (mw_full_q)   grant = G_MW;
            else if (bk_byte_req) grant = G_BK;
        end

        case (grant)
            G_CPU: begin
                ram_addr = cpu_addr;
                ram_d    = cpu_di;
                ram_we   = cpu_wr;
            end
            G_MW: begin
                ram_addr = mw_addr_q;
                ram_d    = mw_data_q;
                ram_we   = 1'b1;
            end
            G_BK: begin
                ram_addr = bk_byte_addr;
                ram_d    = bk_byte_d;
                ram_we   = bk_byte_we;
            end
            default: ;
        endcase

        // A request landing on the drain cycle refills the slot being freed.
        if (mw_req && (!mw_full_q || grant == G_MW)) begin
            mw_full_d = 1'b1;
            mw_addr_d = mw_addr;
            mw_data_d = mw_data;
        end else if (grant == G_MW) begin
            mw_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mw_full_q    <= 1'b0;
            mw_addr_q    <= '0;
            mw_data_q    <= '0;
            ram_addr_q   <= '0;
            ram_d_q      <= '0;
            cpu_do_q     <= 8'hFF;
            cpu_rd_iss_q <= 1'b0;
        end else begin
            mw_full_q    <= mw_full_d;
            mw_addr_q    <= mw_addr_d;
            mw_data_q    <= mw_data_d;
            ram_addr_q   <= ram_addr;
            ram_d_q      <= ram_d;
            cpu_rd_iss_q <= (grant == G_CPU) & ~cpu_wr;
            if (cpu_rd_iss_q) cpu_do_q <= ram_q;
        end
    end

    assign mw_busy = mw_full_q;
    assign cpu_do  = cpu_rd_iss_q ? ram_q : cpu_do_q;

endmodule
